// File: rtl/osd_spi_tx_pkg.sv
// Shared constants, encodings and helpers for the OSD SPI command master.
// OSD_TX_FRAME_EN widens the byte counter and enables the full-frame op.
package osd_spi_tx_pkg;

    localparam logic [7:0] OSD_CMD_WRITE  = 8'h20;
    localparam logic [7:0] OSD_CMD_ENABLE = 8'h40;
    localparam int         OSD_LINE_BYTES = 256;
    localparam int         OSD_LINES      = 8;

`ifdef OSD_TX_FRAME_EN
    localparam int BCNT_W = 12;
`else
    localparam int BCNT_W = 9;
`endif

    typedef logic [BCNT_W-1:0] bcnt_t;

    typedef enum logic [1:0] {
        OP_ENABLE = 2'd0,
        OP_LINE   = 2'd1,
        OP_FRAME  = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_STALL = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

    function automatic logic [7:0] cmd_byte(op_e op, logic [2:0] line, logic en);
        case (op)
            OP_ENABLE: return OSD_CMD_ENABLE | {7'd0, en};
            OP_LINE:   return OSD_CMD_WRITE | {5'd0, line};
            default:   return OSD_CMD_WRITE;
        endcase
    endfunction

    function automatic bcnt_t payload_len(op_e op);
        case (op)
            OP_LINE:  return bcnt_t'(OSD_LINE_BYTES);
`ifdef OSD_TX_FRAME_EN
            OP_FRAME: return bcnt_t'(OSD_LINE_BYTES * OSD_LINES);
`endif
            default:  return '0;
        endcase
    endfunction

    function automatic logic op_has_spi(op_e op);
        case (op)
            OP_ENABLE, OP_LINE: return 1'b1;
`ifdef OSD_TX_FRAME_EN
            OP_FRAME:           return 1'b1;
`endif
            default:            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/osd_spi_sck_tick.sv
// Half-period tick generator: pulses every CLK_DIV cycles while run_i is high.
// clear_i restarts the count so the next half-period is always full length.
module osd_spi_sck_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int            CW   = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (run_i)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    assign tick_o = run_i && !clear_i && (cnt_q == LAST);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/osd_spi_tx.sv
// SPI master serialising OSD commands and line/frame payloads onto SCK/SS3/DI.
// Build with OSD_TX_FRAME_EN to stream a whole 2048-byte frame for cmd_op=2.
module osd_spi_tx
    import osd_spi_tx_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int SS_GAP  = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_line,
    input  logic       cmd_en,
    input  logic       dat_valid,
    output logic       dat_ready,
    input  logic [7:0] dat_byte,
    output logic       busy,
    output logic       done,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DI
);

    localparam int            GW       = $clog2(SS_GAP + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(SS_GAP - 1);

    state_e        state_q;
    logic          sck_q, ss_q, di_q;
    logic          cmd_ready_q, dat_ready_q, busy_q, done_q;
    logic [6:0]    sh_q;
    logic [2:0]    bit_q;
    bcnt_t         bcnt_q;
    logic [GW-1:0] gap_q;

    op_e        op;
    logic [7:0] cb;
    logic       hs;
    logic       run, tick;

    assign op  = op_e'(cmd_op);
    assign cb  = cmd_byte(op, cmd_line, cmd_en);
    assign hs  = cmd_valid && cmd_ready_q;
    assign run = (state_q == ST_SETUP) || (state_q == ST_SHIFT)
              || (state_q == ST_HOLD);

    osd_spi_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .run_i   (run),
        .clear_i (!run),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            di_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
            dat_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sh_q        <= '0;
            bit_q       <= '0;
            bcnt_q      <= '0;
            gap_q       <= '0;
        end else begin
            dat_ready_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (hs) begin
                        cmd_ready_q <= 1'b0;
                        if (op_has_spi(op)) begin
                            state_q <= ST_SETUP;
                            busy_q  <= 1'b1;
                            ss_q    <= 1'b0;
                            di_q    <= cb[7];
                            sh_q    <= cb[6:0];
                            bit_q   <= 3'd7;
                            bcnt_q  <= payload_len(op);
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                // SETUP doubles as the low half of bit 7
                ST_SETUP: begin
                    if (tick) begin
                        sck_q   <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        sck_q <= !sck_q;
                        if (sck_q) begin
                            if (bit_q != 3'd0) begin
                                bit_q <= bit_q - 3'd1;
                                di_q  <= sh_q[6];
                                sh_q  <= {sh_q[5:0], 1'b0};
                            end else if (bcnt_q == '0) begin
                                state_q <= ST_HOLD;
                            end else if (dat_valid) begin
                                dat_ready_q <= 1'b1;
                                di_q        <= dat_byte[7];
                                sh_q        <= dat_byte[6:0];
                                bit_q       <= 3'd7;
                                bcnt_q      <= bcnt_q - 1'b1;
                            end else begin
                                state_q <= ST_STALL;
                            end
                        end
                    end
                end
                // resume with a full low half-period before the next rise
                ST_STALL: begin
                    if (dat_valid) begin
                        state_q     <= ST_SHIFT;
                        dat_ready_q <= 1'b1;
                        di_q        <= dat_byte[7];
                        sh_q        <= dat_byte[6:0];
                        bit_q       <= 3'd7;
                        bcnt_q      <= bcnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        ss_q    <= 1'b1;
                        done_q  <= 1'b1;
                        gap_q   <= GAP_LAST;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign dat_ready = dat_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign SPI_SCK   = sck_q;
    assign SPI_SS3   = ss_q;
    assign SPI_DI    = di_q;

endmodule

// File: tb/tb_osd_spi_tx.sv
// Directed bench for osd_spi_tx with an edge-sampled OSD SPI slave model.
`timescale 1ns/1ps
module tb_osd_spi_tx;

    localparam int CLK_DIV = 2;
    localparam int SS_GAP  = 4;

    logic       clk_sys   = 1'b0;
    logic       reset_n   = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = 2'd0;
    logic [2:0] cmd_line  = 3'd0;
    logic       cmd_en    = 1'b0;
    logic       dat_valid = 1'b0;
    logic [7:0] dat_byte  = 8'd0;
    logic       cmd_ready, dat_ready, busy, done;
    logic       SPI_SCK, SPI_SS3, SPI_DI;

    osd_spi_tx #(.CLK_DIV(CLK_DIV), .SS_GAP(SS_GAP)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_line  (cmd_line),
        .cmd_en    (cmd_en),
        .dat_valid (dat_valid),
        .dat_ready (dat_ready),
        .dat_byte  (dat_byte),
        .busy      (busy),
        .done      (done),
        .SPI_SCK   (SPI_SCK),
        .SPI_SS3   (SPI_SS3),
        .SPI_DI    (SPI_DI)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    // slave model state
    logic [7:0]  sr;
    logic [7:0]  last_cmd = 8'h00;
    logic        osd_en   = 1'b0;
    logic [10:0] addr     = '0;
    logic [7:0]  obuf [0:2047];
    int          nb       = 0;
    bit          first    = 1'b1;
    int          rises    = 0;
    int          hi_rises = 0;
    int          windows  = 0;
    int          n_done   = 0;
    int          n_drdy   = 0;
    int          di_viol  = 0;
    logic        prev_di  = 1'b0;
    time         t_hi     = 0;
    time         min_gap  = 0;
    bit          hi_valid = 1'b0;

    always @(posedge SPI_SCK) begin
        if (SPI_SS3) begin
            hi_rises++;
        end else begin
            rises++;
            sr = {sr[6:0], SPI_DI};
            nb++;
            if (nb == 8) begin
                nb = 0;
                if (first) begin
                    first    = 1'b0;
                    last_cmd = sr;
                    if (sr[6]) osd_en = sr[0];
                    if (sr[5]) addr = {sr[2:0], 8'h00};
                end else begin
                    obuf[addr] = sr;
                    addr++;
                end
            end
        end
    end

    always @(posedge SPI_SS3) begin
        nb       = 0;
        first    = 1'b1;
        t_hi     = $time;
        hi_valid = 1'b1;
    end

    always @(negedge SPI_SS3) begin
        windows++;
        if (hi_valid && ($time - t_hi) < min_gap) min_gap = $time - t_hi;
    end

    always @(negedge clk_sys) begin
        if (!SPI_SS3 && SPI_SCK && SPI_DI !== prev_di) di_viol++;
        prev_di = SPI_DI;
        if (done) n_done++;
        if (dat_ready) n_drdy++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int mode, input int i);
        case (mode)
            0:       return 8'(i);
            1:       return 8'(i) ^ 8'hA5;
            2:       return 8'(i * 7);
            default: return ~8'(i);
        endcase
    endfunction

    task automatic clr_stats();
        rises    = 0;
        windows  = 0;
        n_done   = 0;
        n_drdy   = 0;
        min_gap  = 64'd1000000;
        hi_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] line,
                         input logic en, input bit keep);
        int k;
        cmd_op    = op;
        cmd_line  = line;
        cmd_en    = en;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 500) begin
            @(posedge clk_sys); #1;
            k++;
        end
        check("cmd_ready wait", cmd_ready, 1);
        @(posedge clk_sys); #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic feed(input int n, input int mode, input int stall_at,
                        input int abort_at);
        int k;
        int r0;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                dat_valid = 1'b0;
                r0 = 0;
                for (int c = 0; c < 60; c++) begin
                    @(posedge clk_sys); #1;
                    if (c == 40) r0 = rises;
                    if (c == 55) begin
                        check("stall rises", rises - r0, 0);
                        check("stall sck/ss", {SPI_SCK, SPI_SS3}, 2'b00);
                    end
                end
            end
            dat_byte  = pat(mode, i);
            dat_valid = 1'b1;
            if (i == abort_at) begin
                repeat (10) @(posedge clk_sys);
                #2;
                check("pre-abort ss", SPI_SS3, 0);
                reset_n = 1'b0;
                #1;
                check("abort ss/sck", {SPI_SS3, SPI_SCK}, 2'b10);
                dat_valid = 1'b0;
                return;
            end
            k = 0;
            do begin
                @(posedge clk_sys); #1;
                k++;
            end while (!dat_ready && k < 200);
            if (!dat_ready) begin
                check("dat_ready wait", dat_ready, 1);
                break;
            end
        end
        dat_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(posedge clk_sys); #1;
            k++;
        end while (!(!busy && cmd_ready) && k < 3000);
        check("idle", {busy, cmd_ready}, 2'b01);
    endtask

    task automatic check_buf(input string tag, input int base, input int n,
                             input int mode);
        int err;
        err = 0;
        for (int i = 0; i < n; i++)
            if (obuf[11'(base + i)] !== pat(mode, i)) err++;
        check(tag, err, 0);
    endtask

    initial begin
        #12;
        check("reset outs",
              {SPI_SCK, SPI_SS3, SPI_DI, cmd_ready, dat_ready, busy, done},
              7'b0100000);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        check("cmd_ready at release", cmd_ready, 0);
        @(posedge clk_sys); #1;
        check("cmd_ready idle", cmd_ready, 1);

        // enable command
        clr_stats();
        issue(2'd0, 3'd0, 1'b1, 1'b0);
        wait_idle();
        check("op0 rises", rises, 8);
        check("op0 cmd", last_cmd, 8'h41);
        check("op0 enable", osd_en, 1);
        check("op0 done", n_done, 1);
        check("op0 dat_ready", n_drdy, 0);
        check("op0 windows", windows, 1);

        // line 5 write
        clr_stats();
        issue(2'd1, 3'd5, 1'b0, 1'b0);
        feed(256, 0, -1, -1);
        wait_idle();
        check("op1 cmd", last_cmd, 8'h25);
        check("op1 rises", rises, 2056);
        check("op1 dat_ready", n_drdy, 256);
        check("op1 done", n_done, 1);
        check("op1 windows", windows, 1);
        check_buf("line5 buf", 32'h500, 256, 0);
        check("line5 last", obuf[11'h5FF], 8'hFF);

        // abort by reset mid-line
        clr_stats();
        issue(2'd1, 3'd7, 1'b0, 1'b0);
        feed(256, 2, -1, 100);
        repeat (2) @(posedge clk_sys);
        #1;
        check("abort hold", {SPI_SS3, SPI_SCK, busy}, 3'b100);
        reset_n = 1'b1;
        @(posedge clk_sys); #1;

        // line 2 after abort, with a source stall before byte 3
        clr_stats();
        issue(2'd1, 3'd2, 1'b0, 1'b0);
        feed(256, 1, 3, -1);
        wait_idle();
        check("line2 cmd", last_cmd, 8'h22);
        check("line2 rises", rises, 2056);
        check("line2 dat_ready", n_drdy, 256);
        check_buf("line2 buf", 32'h200, 256, 1);

        // reserved op with payload offered: acked, nothing sent
        clr_stats();
        dat_byte  = 8'h77;
        dat_valid = 1'b1;
        issue(2'd3, 3'd0, 1'b0, 1'b0);
        wait_idle();
        dat_valid = 1'b0;
        check("op3 rises", rises, 0);
        check("op3 windows", windows, 0);
        check("op3 done", n_done, 1);
        check("op3 dat_ready", n_drdy, 0);

`ifdef OSD_TX_FRAME_EN
        clr_stats();
        issue(2'd2, 3'd0, 1'b0, 1'b0);
        feed(2048, 0, -1, -1);
        wait_idle();
        check("frame cmd", last_cmd, 8'h20);
        check("frame rises", rises, 16392);
        check("frame windows", windows, 1);
        check("frame dat_ready", n_drdy, 2048);
        check_buf("frame buf", 0, 2048, 0);
`else
        clr_stats();
        issue(2'd2, 3'd0, 1'b0, 1'b0);
        wait_idle();
        check("op2 rises", rises, 0);
        check("op2 windows", windows, 0);
        check("op2 done", n_done, 1);
`endif

        // back-to-back with cmd_valid held
        clr_stats();
        issue(2'd0, 3'd0, 1'b0, 1'b1);
        issue(2'd1, 3'd3, 1'b0, 1'b0);
        feed(256, 3, -1, -1);
        wait_idle();
        check("b2b windows", windows, 2);
        check("b2b gap", min_gap >= time'(SS_GAP * 10), 1);
        check("b2b disable", osd_en, 0);
        check("b2b done", n_done, 2);
        check_buf("line3 buf", 32'h300, 256, 3);

        check("sck while ss high", hi_rises, 0);
        check("di change sck high", di_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
